// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of NREQ requesters a burst of up to BURST words
// into a shared FIFO, honouring full (stall) and threshold (no new bursts) flags.
module fifo_wr_arbiter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4,
  localparam int unsigned OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ack,
  input  logic               fifo_full,
  input  logic               fifo_threshold,
  output logic               wr,
  output logic [DW-1:0]      data_fifo,
  output logic               busy,
  output logic [OW-1:0]      owner
);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e          r_state, w_state_nxt;
  logic [OW-1:0]   r_owner, w_owner_nxt;
  logic [OW-1:0]   r_last, w_last_nxt;
  logic [3:0]      r_beat, w_beat_nxt;
  logic [OW-1:0]   w_win;
  logic            w_found;
  logic            w_sel_req;
  logic            w_wr;
  logic [DW-1:0]   w_sel_data;

  // Request and data of the current owner
  always_comb begin
    w_sel_req  = 1'b0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_sel_req  = req[i];
        w_sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // First set request scanning upward from last_owner+1, wrapping
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!w_found && req[j] && (((32'(r_last) + k) % NREQ) == j)) begin
          w_win   = OW'(j);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_wr      = (r_state == StBurst) & w_sel_req & ~fifo_full & ~rst;
  assign wr        = w_wr;
  assign busy      = (r_state == StBurst);
  assign owner     = r_owner;
  assign data_fifo = busy ? w_sel_data : '0;

  always_comb begin
    req_ack = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ack[i] = w_wr && (r_owner == OW'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    case (r_state)
      StIdle: begin
        if ((|req) && !fifo_threshold) begin
          w_state_nxt = StBurst;
          w_owner_nxt = w_win;
          w_beat_nxt  = 4'd0;
        end
      end
      StBurst: begin
        if (!w_sel_req) begin
          w_state_nxt = StIdle;
          w_last_nxt  = r_owner;
        end else if (w_wr) begin
          w_beat_nxt = r_beat + 4'd1;
          if (r_beat == 4'(BURST - 1)) begin
            w_state_nxt = StIdle;
            w_last_nxt  = r_owner;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_last  <= OW'(NREQ - 1);
      r_beat  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a cycle model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int DW    = 32;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   req_ack;
  logic         fifo_full;
  logic         fifo_threshold;
  logic         wr;
  logic [31:0]  data_fifo;
  logic         busy;
  logic [1:0]   owner;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(DW), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .fifo_full      (fifo_full),
    .fifo_threshold (fifo_threshold),
    .wr             (wr),
    .data_fifo      (data_fifo),
    .busy           (busy),
    .owner          (owner)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who is bursting and how many words remain in the grant
  bit m_active;
  int m_owner;
  int m_last;
  int m_left;

  logic       g_wr, g_busy;
  logic [3:0] g_ack;
  logic [1:0] g_owner;
  int         g_wr_cnt;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       wr;
    logic [3:0] ack;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl[26];

  function automatic bit bit_of(input logic [3:0] r, input int idx);
    return ((r >> idx) & 4'd1) != 4'd0;
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (bit_of(r, (last + k) % NREQ)) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 0;
    m_last   = NREQ - 1;
    m_left   = BURST;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      if (req != 4'd0 && !fifo_threshold) begin
        m_owner  = pick(req, m_last);
        m_active = 1'b1;
        m_left   = BURST;
      end
    end else if (!bit_of(req, m_owner)) begin
      m_active = 1'b0;
      m_last   = m_owner;
    end else if (!fifo_full) begin
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0;
        m_last   = m_owner;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic f, input logic t);
    rst            = r;
    req            = q;
    fifo_full      = f;
    fifo_threshold = t;
  endtask

  // Called at posedge+1 with inputs set; samples mid-cycle, then advances one clock
  task automatic step(input string tag);
    logic        e_wr;
    logic [3:0]  e_ack;
    logic [31:0] e_data;
    #3;
    e_wr   = m_active && bit_of(req, m_owner) && !fifo_full && !rst;
    e_ack  = e_wr ? 4'(1 << m_owner) : 4'd0;
    e_data = m_active ? 32'(req_data >> (m_owner * DW)) : 32'd0;
    chk({tag, "/ctl"}, 64'({busy, owner, wr, req_ack}),
        64'({m_active, 2'(m_owner), e_wr, e_ack}));
    chk({tag, "/data"}, 64'(data_fifo), 64'(e_data));
    g_wr    = wr;
    g_busy  = busy;
    g_ack   = req_ack;
    g_owner = owner;
    if (wr === 1'b1) g_wr_cnt++;
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    drive(1'b1, 4'hF, 1'b0, 1'b0);
    g_wr_cnt = 0;

    // Reset row, arbitration cycle, then five bursts rotating 0,1,2,3,0 with one idle gap
    tbl[0] = '{1'b1, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0};
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 4; w++) begin
        tbl[2 + b*5 + w] = '{1'b0, 4'hF, 1'b1, 4'(1 << (b % 4)), 2'(b % 4), 1'b1};
      end
      if (b < 4) tbl[2 + b*5 + 4] = '{1'b0, 4'hF, 1'b0, 4'h0, 2'(b % 4), 1'b0};
    end

    @(posedge clk);
    #1;
    model_reset();

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].req, 1'b0, 1'b0);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d/vec", i), 64'({g_busy, g_owner, g_wr, g_ack}),
          64'({tbl[i].busy, tbl[i].owner, tbl[i].wr, tbl[i].ack}));
    end

    // Full stall after word 2
    drive(1'b1, 4'b0001, 1'b0, 1'b0); step("st_rst");
    drive(1'b0, 4'b0001, 1'b0, 1'b0); step("st_arb");
    g_wr_cnt = 0;
    step("st_w1");
    step("st_w2");
    drive(1'b0, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("st_full");
      chk("stall_wr", 64'({g_wr, g_ack}), 64'd0);
      chk("stall_busy", 64'(g_busy), 64'd1);
    end
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    step("st_w3");
    step("st_w4");
    chk("stall_words", 64'(g_wr_cnt), 64'd4);
    step("st_end");
    chk("stall_end_busy", 64'(g_busy), 64'd0);

    // Early release by requester 2
    drive(1'b1, 4'b1100, 1'b0, 1'b0); step("er_rst");
    drive(1'b0, 4'b1100, 1'b0, 1'b0); step("er_arb");
    step("er_w1");
    chk("er_owner2", 64'({g_owner, g_wr}), 64'({2'd2, 1'b1}));
    drive(1'b0, 4'b1000, 1'b0, 1'b0);
    step("er_drop");
    chk("er_drop_wr", 64'(g_wr), 64'd0);
    step("er_idle");
    chk("er_idle_busy", 64'(g_busy), 64'd0);
    step("er_next");
    chk("er_next_owner3", 64'({g_busy, g_owner, g_ack}), 64'({1'b1, 2'd3, 4'b1000}));

    // Threshold blocks new bursts but not one in progress
    drive(1'b1, 4'b0001, 1'b0, 1'b0); step("th_rst");
    drive(1'b0, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("th_block");
      chk("th_no_grant", 64'({g_busy, g_wr}), 64'd0);
    end
    drive(1'b0, 4'b0001, 1'b0, 1'b0); step("th_arb");
    g_wr_cnt = 0;
    step("th_w1");
    drive(1'b0, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("th_wn");
    chk("th_words", 64'(g_wr_cnt), 64'd4);
    step("th_after");
    chk("th_after_busy", 64'(g_busy), 64'd0);

    // Reset in the middle of requester 1's burst
    drive(1'b1, 4'hF, 1'b0, 1'b0); step("rb_rst");
    drive(1'b0, 4'hF, 1'b0, 1'b0); step("rb_arb");
    for (int i = 0; i < 4; i++) step("rb_b0");
    step("rb_gap");
    step("rb_w1");
    chk("rb_owner1", 64'({g_owner, g_wr}), 64'({2'd1, 1'b1}));
    drive(1'b1, 4'hF, 1'b0, 1'b0);
    step("rb_mid");
    chk("rb_mid_wr", 64'({g_wr, g_ack}), 64'd0);
    drive(1'b0, 4'hF, 1'b0, 1'b0);
    step("rb_rel");
    chk("rb_rel_idle", 64'({g_busy, g_owner, g_wr}), 64'd0);
    step("rb_first");
    chk("rb_first_grant0", 64'({g_busy, g_owner, g_ack}), 64'({1'b1, 2'd0, 4'b0001}));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] q;
      q = ($urandom_range(0, 9) < 7) ? req : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) == 0), q, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
      req_data = {$urandom, $urandom, $urandom, $urandom};
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32: pixel word width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4: number of write requesters (2..8).
REQ-003 The block SHALL have parameter BURST, default 4: maximum words granted per arbitration win (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ bits: bit i high = requester i holds a valid word.
REQ-007 The block SHALL have port req_data, input, NREQ*DW bits: word of requester i in bits [i*DW +: DW].
REQ-008 The block SHALL have port req_ack, output, NREQ bits: one-hot; bit i high = requester i's word is written this cycle.
REQ-009 The block SHALL have port fifo_full, input, 1 bit: FIFO full status.
REQ-010 The block SHALL have port fifo_threshold, input, 1 bit: FIFO at or above half full.
REQ-011 The block SHALL have port wr, output, 1 bit: FIFO write strobe.
REQ-012 The block SHALL have port data_fifo, output, DW bits: FIFO write data.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BURST.
REQ-014 The block SHALL have port owner, output, clog2(NREQ) bits: index of the current/last granted requester.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-016 In IDLE, when any req bit is high and fifo_threshold=0, the FSM SHALL go to BURST next cycle.
- The winner SHALL be the first set req bit scanning upward, with wrap, from last_owner+1.
- On that transition, owner SHALL take the winner index and beat count SHALL clear to 0.
REQ-017 In IDLE, when fifo_threshold=1, the FSM SHALL stay in IDLE; no new burst starts, regardless of req.
REQ-018 In IDLE, wr and req_ack SHALL be 0; arbitration latency from req to first possible wr SHALL be 1 cycle.
REQ-019 In BURST, the write path SHALL be combinational:
- wr = req[owner] & ~fifo_full & ~rst
- req_ack = wr << owner
- data_fifo = req_data slice of owner.
REQ-020 Outside BURST, data_fifo SHALL be 0.
REQ-021 Each cycle with wr=1 SHALL increment the beat count (4-bit counter) by 1.
REQ-022 The burst SHALL end (FSM to IDLE, last_owner <= owner) on whichever occurs first:
- a write with beat count = BURST-1
- req[owner]=0 in a BURST cycle.
REQ-023 fifo_full=1 in BURST SHALL stall the burst: wr=0, no ack, count held, FSM stays in BURST even if fifo_threshold=1.
REQ-024 wr SHALL never be 1 in a cycle where fifo_full=1 (no overflow from this block).
REQ-025 fifo_threshold SHALL NOT affect a burst already in progress.
REQ-026 A requester whose req is high SHALL be granted within NREQ-1 other bursts, provided fifo_threshold is not permanently high.
REQ-027 busy SHALL equal (state==BURST); owner SHALL hold its value in IDLE.

Reset
REQ-028 On a rising clk edge with rst=1, the block SHALL set state=IDLE, beat count=0, owner=0 and last_owner=NREQ-1, so requester 0 has first priority.
REQ-029 While rst=1, wr and req_ack SHALL be 0 combinationally, including mid-burst; the interrupted burst SHALL be abandoned with no further acks.
REQ-030 After rst falls, the first grant SHALL occur no earlier than one cycle later.

Verification
REQ-031 Reset state: after reset with req=4'b1111 and flags low, the bench SHALL check owner=0, 4 acks on cycles 2-5, then owner=1.
REQ-032 Round-robin rotation: with all requesters held, the bench SHALL check grant order 0,1,2,3,0, each a 4-word burst with 1 idle cycle between bursts.
REQ-033 Full stall: fifo_full=1 for 3 cycles mid-burst (after word 2) SHALL give wr=0 and ack=0 for 3 cycles; words 3-4 SHALL follow, with 4 words total and no duplicates.
REQ-034 Early release: requester 2 drops req after 1 word SHALL end the burst; the next cycle is IDLE and requester 3 is granted next.
REQ-035 Threshold: fifo_threshold=1 in IDLE with req=4'b0001 SHALL give no grant; fifo_threshold=1 asserted mid-burst SHALL still let the burst complete all 4 words.
REQ-036 Reset mid-burst: rst=1 after word 1 SHALL give wr=0 that cycle; after release, the bench SHALL check owner=0 and requester 0 is granted first.
